// File: rtl/slv_guard_rst_ctrl.sv
// Recovery sequencer for a guarded AXI slave: isolate, drain, hold in reset,
// settle, de-isolate. Sticky status and interrupt for software.
module slv_guard_rst_ctrl #(
   parameter int unsigned CntWidth     = 16,
   parameter int unsigned RstCntWidth  = 8,
   parameter int unsigned MinRstCycles = 2
) (
   input  logic                   clk,
   input  logic                   rst_n,
   input  logic                   rst_req_i,
   input  logic                   ena_i,
   input  logic [CntWidth-1:0]    drain_budget_i,
   input  logic [CntWidth-1:0]    rst_hold_i,
   input  logic [CntWidth-1:0]    recover_i,
   input  logic                   isolated_i,
   input  logic                   irq_ack_i,
   output logic                   isolate_o,
   output logic                   slv_rst_no,
   output logic                   busy_o,
   output logic                   irq_o,
   output logic                   drain_to_o,
   output logic [RstCntWidth-1:0] rst_cnt_o,
   output logic [2:0]             state_o
);

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ISOLATE = 3'd1,
      RESET   = 3'd2,
      RECOVER = 3'd3,
      RELEASE = 3'd4
   } state_e;

   localparam logic [CntWidth-1:0]    CntOne  = CntWidth'(1);
   localparam logic [CntWidth-1:0]    MinHold = CntWidth'(MinRstCycles);
   localparam logic [RstCntWidth-1:0] RstOne  = RstCntWidth'(1);

   state_e                 state_q;
   logic [CntWidth-1:0]    cnt_q;
   logic                   isolate_q;
   logic                   slv_rst_n_q;
   logic                   busy_q;
   logic                   irq_q;
   logic                   drain_to_q;
   logic [RstCntWidth-1:0] rst_cnt_q;

   logic [CntWidth-1:0]    hold_eff_d;
   logic [CntWidth-1:0]    hold_last_d;
   logic [CntWidth-1:0]    rec_last_d;

   // Counters run 0..N-1, so compare against the last index; a zero recover
   // time still spends one cycle in RECOVER.
   assign hold_eff_d  = (rst_hold_i > MinHold) ? rst_hold_i : MinHold;
   assign hold_last_d = hold_eff_d - CntOne;
   assign rec_last_d  = (recover_i == '0) ? '0 : recover_i - CntOne;

   always_ff @(posedge clk or posedge rst_n) begin
      if (rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         isolate_q   <= 1'b0;
         slv_rst_n_q <= 1'b1;
         busy_q      <= 1'b0;
         irq_q       <= 1'b0;
         drain_to_q  <= 1'b0;
         rst_cnt_q   <= '0;
      end else begin
         // Ack first so a same-cycle set event below overrides it.
         if (irq_ack_i) begin
            irq_q      <= 1'b0;
            drain_to_q <= 1'b0;
         end
         case (state_q)
            IDLE: begin
               if (rst_req_i && ena_i) begin
                  state_q   <= ISOLATE;
                  isolate_q <= 1'b1;
                  busy_q    <= 1'b1;
                  cnt_q     <= '0;
               end
            end
            ISOLATE: begin
               if (isolated_i) begin
                  state_q     <= RESET;
                  slv_rst_n_q <= 1'b0;
                  cnt_q       <= '0;
               end else if (cnt_q == drain_budget_i) begin
                  state_q     <= RESET;
                  slv_rst_n_q <= 1'b0;
                  drain_to_q  <= 1'b1;
                  cnt_q       <= '0;
               end else begin
                  cnt_q <= cnt_q + CntOne;
               end
            end
            RESET: begin
               if (cnt_q == hold_last_d) begin
                  state_q     <= RECOVER;
                  slv_rst_n_q <= 1'b1;
                  cnt_q       <= '0;
               end else begin
                  cnt_q <= cnt_q + CntOne;
               end
            end
            RECOVER: begin
               if (cnt_q == rec_last_d) begin
                  state_q   <= RELEASE;
                  isolate_q <= 1'b0;
                  cnt_q     <= '0;
               end else begin
                  cnt_q <= cnt_q + CntOne;
               end
            end
            RELEASE: begin
               if (!isolated_i) begin
                  state_q <= IDLE;
                  busy_q  <= 1'b0;
                  irq_q   <= 1'b1;
                  if (rst_cnt_q != '1) rst_cnt_q <= rst_cnt_q + RstOne;
               end
            end
            default: begin
               state_q     <= IDLE;
               cnt_q       <= '0;
               isolate_q   <= 1'b0;
               slv_rst_n_q <= 1'b1;
               busy_q      <= 1'b0;
            end
         endcase
      end
   end

   assign isolate_o  = isolate_q;
   assign slv_rst_no = slv_rst_n_q;
   assign busy_o     = busy_q;
   assign irq_o      = irq_q;
   assign drain_to_o = drain_to_q;
   assign rst_cnt_o  = rst_cnt_q;
   assign state_o    = state_q;

endmodule

// File: doc/slv_guard_rst_ctrl.md
Name: slv_guard_rst_ctrl

Overview:
- Sits directly downstream of the slave guard top: consumes the guard's reset request and drives recovery of the monitored AXI slave.
- On a request, the sequence is:
  - isolate the slave port (through an external AXI isolate stage);
  - wait for drain, or give up on timeout;
  - hold the slave in reset for a programmable time;
  - let it settle;
  - de-isolate.
- Exposes sticky status and an interrupt to software.

Parameters:
- CntWidth, 16, width of all cycle counters and budget inputs.
- RstCntWidth, 8, width of the saturating reset-event counter.
- MinRstCycles, 2, floor applied to the reset hold time.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-high.
- rst_req_i  in  1  reset request from slave guard; level or pulse, sampled every cycle.
- ena_i  in  1  controller enable; when 0, requests are ignored in IDLE.
- drain_budget_i  in  CntWidth  max cycles to wait for isolated_i after isolate_o is raised.
- rst_hold_i  in  CntWidth  cycles to hold slv_rst_no low; effective value is max(rst_hold_i, MinRstCycles).
- recover_i  in  CntWidth  cycles to wait after reset release before de-isolating.
- isolated_i  in  1  from isolate stage: 1 = port isolated and no outstanding transactions.
- irq_ack_i  in  1  single-cycle clear of irq_o and sticky flags.
- isolate_o  out  1  isolation request to the isolate stage.
- slv_rst_no  out  1  active-low reset to the monitored slave.
- busy_o  out  1  high in any state other than IDLE.
- irq_o  out  1  sticky interrupt, set on sequence completion.
- drain_to_o  out  1  sticky flag: drain budget expired during the last sequence.
- rst_cnt_o  out  RstCntWidth  number of completed reset sequences; saturates at all-ones.
- state_o  out  3  current FSM state encoding, for debug.

Behaviour:
- Reset:
  - Reset asserted (rst_n=1) forces state IDLE, cnt=0, isolate_o=0, slv_rst_no=1, irq_o=0, drain_to_o=0, rst_cnt_o=0.
  - A reset applied mid-sequence aborts immediately, with outputs as above.
- State encoding: IDLE=0, ISOLATE=1, RESET=2, RECOVER=3, RELEASE=4.
- All outputs are registered; transitions occur on posedge clk.
- IDLE:
  - If rst_req_i & ena_i, go to ISOLATE next cycle; isolate_o=1 from that edge; cnt=0.
- ISOLATE:
  - Each cycle: if isolated_i, go to RESET, cnt=0.
  - Else if cnt == drain_budget_i, set drain_to_o=1, go to RESET, cnt=0.
  - Else cnt++.
  - drain_budget_i=0 with isolated_i=0 times out after exactly 1 cycle in ISOLATE.
  - isolated_i has priority over timeout when both hold in the same cycle; drain_to_o is not set.
- RESET:
  - slv_rst_no=0 for exactly H = max(rst_hold_i, MinRstCycles) cycles: cnt counts 0..H-1, then go to RECOVER, cnt=0.
  - slv_rst_no returns to 1 on the same edge that enters RECOVER.
- RECOVER:
  - Wait recover_i cycles; recover_i=0 leaves after 1 cycle. Then go to RELEASE.
- RELEASE:
  - isolate_o=0. Wait until isolated_i=0, then go to IDLE.
  - On that edge: irq_o=1 and rst_cnt_o++ (saturating, no wrap).
- Budget inputs are sampled each cycle. Software must not change them while busy_o=1; behaviour under such changes is defined only by the comparisons above.
- rst_req_i while not IDLE is ignored. A request still asserted on return to IDLE starts a new sequence the next cycle; there is no queuing.
- irq_ack_i clears irq_o and drain_to_o.
  - If ack and a set event coincide in the same cycle, set wins.
- rst_cnt_o is cleared only by reset, never by irq_ack_i.
- ena_i=0 does not abort a sequence already in progress.
- Counters are CntWidth wide, compared by equality, and never wrap within a state, because budgets are ≤ 2^CntWidth-1.

Test Plan:
1. Nominal: drain_budget=10, rst_hold=4, recover=3; isolated_i rises 2 cycles after isolate_o and falls 1 cycle after de-isolate → slv_rst_no low for exactly 4 cycles, irq_o=1, rst_cnt_o=1, drain_to_o=0, busy_o low in IDLE.
2. Drain timeout: isolated_i stuck 0, drain_budget=5 → RESET entered after 6 cycles in ISOLATE, drain_to_o=1; irq_ack_i clears both irq_o and drain_to_o.
3. Floor and zero budgets: rst_hold=0, recover=0, drain_budget=0, MinRstCycles=2 → slv_rst_no low for 2 cycles, RECOVER lasts 1 cycle.
4. Simultaneous events:
   - isolated_i rises on the timeout cycle → drain_to_o stays 0.
   - irq_ack_i on the completion edge → irq_o=1.
   - rst_req_i held high continuously → back-to-back sequences, rst_cnt_o increments once per sequence.
5. Reset mid-RESET state (rst_n=1 asynchronously) → slv_rst_no=1, isolate_o=0, state_o=0 immediately, rst_cnt_o=0.
6. Saturation with RstCntWidth=2: run 5 sequences → rst_cnt_o=3. ena_i=0 in IDLE with rst_req_i=1 → no sequence starts, busy_o=0.
